// File: rtl/key_event_queue.sv
// key_event_queue
//   Converts debounced key levels into discrete press/release events.
//   Each key has a small slot that detects edges and keeps two pending
//   bits, one for press and one for release. A fixed-priority arbiter
//   (lowest index wins) moves one pending edge per cycle into a FIFO.
//   The FIFO drains over a valid/ready interface.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   keys_in       : debounced key levels (1 = pressed)
//   evt_valid     : FIFO head holds an event
//   evt_ready     : consumer takes the head this cycle
//   evt_key       : key index of the head event
//   evt_press     : 1 = press, 0 = release
//   held_keys     : keys_in delayed by one cycle
//   fifo_count    : FIFO occupancy
//   overflow      : sticky flag; an edge was lost
//   overflow_clr  : clears overflow (a simultaneous new loss wins)

// Per-key edge detector and pending state.
module kq_key_slot (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  input  logic clr_press,
  input  logic clr_rel,
  output logic key_prev,
  output logic pend_press,
  output logic pend_rel,
  output logic ovf_set
);
  logic rise, fall;

  assign rise = key_in & ~key_prev;
  assign fall = ~key_in & key_prev;

  // A repeat edge is lost only if the bit is already pending and is not
  // being drained this same cycle.
  assign ovf_set = (rise & pend_press & ~clr_press) |
                   (fall & pend_rel & ~clr_rel);

  always_ff @(posedge clk) begin
    if (reset) begin
      key_prev   <= 1'b0;
      pend_press <= 1'b0;
      pend_rel   <= 1'b0;
    end else begin
      key_prev   <= key_in;
      // A new edge wins over a same-cycle clear.
      pend_press <= (pend_press & ~clr_press) | rise;
      pend_rel   <= (pend_rel & ~clr_rel) | fall;
    end
  end
endmodule

module key_event_queue #(
  parameter int NUM_KEYS   = 8,
  parameter int IDX_W      = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_KEYS-1:0]           keys_in,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [IDX_W-1:0]              evt_key,
  output logic                          evt_press,
  output logic [NUM_KEYS-1:0]           held_keys,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          overflow_clr
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [NUM_KEYS-1:0] keys_prev, pend_press, pend_rel, ovf_set;
  logic [NUM_KEYS-1:0] clr_press, clr_rel, pend_any;

  kq_key_slot u_slot [NUM_KEYS-1:0] (
    .clk        (clk),
    .reset      (reset),
    .key_in     (keys_in),
    .clr_press  (clr_press),
    .clr_rel    (clr_rel),
    .key_prev   (keys_prev),
    .pend_press (pend_press),
    .pend_rel   (pend_rel),
    .ovf_set    (ovf_set)
  );

  assign held_keys = keys_prev;
  assign pend_any  = pend_press | pend_rel;

  // Lowest-index pending key.
  logic             sel_valid;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_dir;

  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (pend_any[k]) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(k);
      end
    end
  end

  // With both pending, the current level tells the order: a key now up
  // was pressed then released (press first); a key now down was
  // released then pressed (release first).
  assign sel_dir = pend_press[sel_idx] &
                   (~pend_rel[sel_idx] | ~keys_prev[sel_idx]);

  // FIFO
  logic [IDX_W:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic             pop, push;

  assign evt_valid = (fifo_count != '0);
  assign pop       = evt_valid & evt_ready;
  assign push      = sel_valid & ((fifo_count < DEPTH_C) | pop);
  assign evt_key   = mem[rptr][IDX_W:1];
  assign evt_press = mem[rptr][0];

  always_comb begin
    clr_press = '0;
    clr_rel   = '0;
    if (push) begin
      if (sel_dir) clr_press = NUM_KEYS'(1) << sel_idx;
      else         clr_rel   = NUM_KEYS'(1) << sel_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= {sel_idx, sel_dir};
        wptr      <= wptr + PTR_W'(1);
      end
      if (pop) rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      overflow <= (|ovf_set) | (overflow & ~overflow_clr);
    end
  end
endmodule
